// File: rtl/sample_feeder.sv
// Sample memory plus run-control FSM that streams stored samples to a training controller.
// Optional epoch limit (max_epoch / limit_hit) is enabled by defining SAMPLE_FEEDER_EPOCH_LIMIT_EN.
module sample_feeder #(
    parameter int DEPTH = 64,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DW-1:0]            wr_x1,
    input  logic [DW-1:0]            wr_x2,
    input  logic [DW-1:0]            wr_t,
    input  logic [31:0]              n_cfg,
    input  logic                     go,
    input  logic                     ready,
    input  logic                     reinit,
    input  logic                     done,
    output logic                     start,
    output logic [31:0]              n_bus,
    output logic [DW-1:0]            x1,
    output logic [DW-1:0]            x2,
    output logic [DW-1:0]            t,
    output logic                     busy,
    output logic                     cfg_err,
    output logic [15:0]              epoch_cnt
`ifdef SAMPLE_FEEDER_EPOCH_LIMIT_EN
    ,
    input  logic [15:0]              max_epoch,
    output logic [0:0]               limit_hit
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] DEPTH32 = 32'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, FEED, FINISH} stateT;

    stateT state, nextState;
    logic [1:0] rstPipe;
    logic rstnInt;
    logic [3*DW-1:0] mem [DEPTH];
    logic [AW-1:0] idx, idxNext;
    logic cfgBad, idxWrap, limitReached, feedStep;

    // Reset asserts immediately but releases only after two clock edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rstPipe <= 2'b00;
        else        rstPipe <= {rstPipe[0], 1'b1};
    end
    assign rstnInt = rstPipe[1];

    assign cfgBad  = (n_cfg == 32'd0) || (n_cfg > DEPTH32);
    assign idxWrap = (({{(32-AW){1'b0}}, idx} + 32'd1) == n_bus);
    assign idxNext = idxWrap ? {AW{1'b0}} : idx + AW'(1);

`ifdef SAMPLE_FEEDER_EPOCH_LIMIT_EN
    assign limitReached = (state == FEED) && (max_epoch != 16'd0) && (epoch_cnt == max_epoch);
`else
    assign limitReached = 1'b0;
`endif

    // done takes priority over everything else a FEED cycle could do
    assign feedStep = (state == FEED) && !done && !limitReached;

    always_ff @(posedge clk or negedge rstnInt) begin
        if (!rstnInt) state <= IDLE;
        else          state <= nextState;
    end

    always_comb begin
        nextState = state;
        start     = 1'b0;
        case (state)
            IDLE:    if (go && !cfgBad) nextState = START;
            START: begin
                start     = 1'b1;
                nextState = FEED;
            end
            FEED:    if (done || limitReached) nextState = FINISH;
            FINISH:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstnInt && state == IDLE && wr_en) mem[wr_addr] <= {wr_x1, wr_x2, wr_t};
    end

    always_ff @(posedge clk or negedge rstnInt) begin
        if (!rstnInt) begin
            n_bus     <= 32'd0;
            idx       <= {AW{1'b0}};
            epoch_cnt <= 16'd0;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
            x1        <= {DW{1'b0}};
            x2        <= {DW{1'b0}};
            t         <= {DW{1'b0}};
        end else begin
            cfg_err <= (state == IDLE) && go && cfgBad;
            case (state)
                IDLE: begin
                    if (go && !cfgBad) begin
                        n_bus     <= n_cfg;
                        idx       <= {AW{1'b0}};
                        epoch_cnt <= 16'd0;
                    end
                end
                START: busy <= 1'b1;
                FEED: begin
                    if (feedStep) begin
                        if (reinit && epoch_cnt != 16'hFFFF) epoch_cnt <= epoch_cnt + 16'd1;
                        if (ready) begin
                            if (reinit) begin
                                {x1, x2, t} <= mem[0];
                                idx         <= (n_bus == 32'd1) ? {AW{1'b0}} : AW'(1);
                            end else begin
                                {x1, x2, t} <= mem[idx];
                                idx         <= idxNext;
                            end
                        end
                    end
                end
                FINISH: busy <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef SAMPLE_FEEDER_EPOCH_LIMIT_EN
    always_ff @(posedge clk or negedge rstnInt) begin
        if (!rstnInt) limit_hit <= 1'b0;
        else          limit_hit <= limitReached && !done;
    end
`endif

endmodule

// File: tb/tb_sample_feeder.sv
// Self-checking bench for sample_feeder: directed vector table, reset corner cases,
// and randomized runs against a queue-free arithmetic reference model.
module tb_sample_feeder;

    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        logic        go;
        logic        ready;
        logic        reinit;
        logic        done;
        logic        wrEn;
        logic [31:0] nCfg;
        logic        expStart;
        logic        expBusy;
        logic        expCfgErr;
        int          expSample;
        int          expEpoch;
    } vecT;

    logic clk = 1'b0;
    logic rst_n;
    logic wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_x1, wr_x2, wr_t;
    logic [31:0] n_cfg;
    logic go, ready, reinit, done;
    logic start, busy, cfg_err;
    logic [31:0] n_bus;
    logic [DW-1:0] x1, x2, t;
    logic [15:0] epoch_cnt;
`ifdef SAMPLE_FEEDER_EPOCH_LIMIT_EN
    logic [15:0] max_epoch = 16'd0;
    logic [0:0] limit_hit;
`endif

    int compared = 0;
    int mismatched = 0;

    vecT vecs[20];
    logic [3*DW-1:0] modelMem [DEPTH];
    logic [3*DW-1:0] mX;
    int mIdx, mEpoch, mN;

    always #5 clk = ~clk;

    sample_feeder #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_t(wr_t), .n_cfg(n_cfg),
        .go(go), .ready(ready), .reinit(reinit), .done(done),
        .start(start), .n_bus(n_bus), .x1(x1), .x2(x2), .t(t),
        .busy(busy), .cfg_err(cfg_err), .epoch_cnt(epoch_cnt)
`ifdef SAMPLE_FEEDER_EPOCH_LIMIT_EN
        , .max_epoch(max_epoch), .limit_hit(limit_hit)
`endif
    );

    function automatic logic [3*DW-1:0] sampleWord(input int i);
        if (i < 0) return '0;
        return {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i)};
    endfunction

    function automatic vecT mk(input logic g, r, ri, d, w, input logic [31:0] n,
                               input logic eS, eB, eE, input int eSam, eEp);
        vecT v;
        v.go = g; v.ready = r; v.reinit = ri; v.done = d; v.wrEn = w; v.nCfg = n;
        v.expStart = eS; v.expBusy = eB; v.expCfgErr = eE; v.expSample = eSam; v.expEpoch = eEp;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic g, r, ri, d, w, input logic [31:0] n);
        go = g; ready = r; reinit = ri; done = d; wr_en = w; n_cfg = n;
        step();
        go = 1'b0; ready = 1'b0; reinit = 1'b0; done = 1'b0; wr_en = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " start"}, 128'(start), 128'(0));
        checkOutput({tag, " busy"}, 128'(busy), 128'(0));
        checkOutput({tag, " cfg_err"}, 128'(cfg_err), 128'(0));
        checkOutput({tag, " n_bus"}, 128'(n_bus), 128'(0));
        checkOutput({tag, " sample"}, 128'({x1, x2, t}), 128'(0));
        checkOutput({tag, " epoch"}, 128'(epoch_cnt), 128'(0));
    endtask

    task automatic writeSample(input int a, input logic [3*DW-1:0] w);
        wr_addr = AW'(a);
        {wr_x1, wr_x2, wr_t} = w;
        applyStimulus(0, 0, 0, 0, 1, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_x1 = '0; wr_x2 = '0; wr_t = '0;
        n_cfg = 32'd0; go = 1'b0; ready = 1'b0; reinit = 1'b0; done = 1'b0;

        step(); step();
        checkAllZero("reset");
        rst_n = 1'b1;
        step(); step(); step();

        for (int i = 0; i < 4; i++) writeSample(i, sampleWord(i));

        vecs[0]  = mk(1, 0, 0, 0, 0, 32'd4,  1, 0, 0, -1, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 32'd0,  0, 1, 0, -1, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 32'd0,  0, 1, 0,  0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 32'd0,  0, 1, 0,  1, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 32'd0,  0, 1, 0,  2, 0);
        vecs[5]  = mk(0, 1, 0, 0, 1, 32'd0,  0, 1, 0,  3, 0);
        vecs[6]  = mk(0, 1, 0, 0, 0, 32'd0,  0, 1, 0,  0, 0);
        vecs[7]  = mk(0, 1, 0, 0, 0, 32'd0,  0, 1, 0,  1, 0);
        vecs[8]  = mk(0, 1, 0, 0, 0, 32'd0,  0, 1, 0,  2, 0);
        vecs[9]  = mk(0, 1, 1, 0, 0, 32'd0,  0, 1, 0,  0, 1);
        vecs[10] = mk(0, 1, 0, 0, 0, 32'd0,  0, 1, 0,  1, 1);
        vecs[11] = mk(0, 0, 1, 0, 0, 32'd0,  0, 1, 0,  1, 2);
        vecs[12] = mk(0, 0, 0, 0, 0, 32'd0,  0, 1, 0,  1, 2);
        vecs[13] = mk(0, 1, 0, 0, 0, 32'd0,  0, 1, 0,  2, 2);
        vecs[14] = mk(0, 1, 0, 1, 1, 32'd0,  0, 1, 0,  2, 2);
        vecs[15] = mk(0, 0, 0, 0, 0, 32'd0,  0, 0, 0,  2, 2);
        vecs[16] = mk(1, 0, 0, 0, 0, 32'd0,  0, 0, 1,  2, 2);
        vecs[17] = mk(0, 0, 0, 0, 0, 32'd0,  0, 0, 0,  2, 2);
        vecs[18] = mk(1, 0, 0, 0, 0, 32'(DEPTH + 1), 0, 0, 1, 2, 2);
        vecs[19] = mk(0, 0, 0, 0, 0, 32'd0,  0, 0, 0,  2, 2);

        for (int i = 0; i < 20; i++) begin
            wr_addr = (i == 5) ? AW'(1) : AW'(0);
            wr_x1 = 32'hDEAD_BEEF; wr_x2 = 32'hDEAD_BEEF; wr_t = 32'hDEAD_BEEF;
            applyStimulus(vecs[i].go, vecs[i].ready, vecs[i].reinit, vecs[i].done,
                          vecs[i].wrEn, vecs[i].nCfg);
            checkOutput($sformatf("vec%0d start", i), 128'(start), 128'(vecs[i].expStart));
            checkOutput($sformatf("vec%0d busy", i), 128'(busy), 128'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d cfg_err", i), 128'(cfg_err), 128'(vecs[i].expCfgErr));
            checkOutput($sformatf("vec%0d sample", i), 128'({x1, x2, t}), 128'(sampleWord(vecs[i].expSample)));
            checkOutput($sformatf("vec%0d epoch", i), 128'(epoch_cnt), 128'(vecs[i].expEpoch));
            checkOutput($sformatf("vec%0d n_bus", i), 128'(n_bus), 128'(4));
        end

        // Reset in the middle of a run, then replay from the retained memory
        applyStimulus(1, 0, 0, 0, 0, 32'd4);
        checkOutput("rerun start", 128'(start), 128'(1));
        applyStimulus(0, 0, 0, 0, 0, 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 32'd0);
        checkOutput("rerun s0", 128'({x1, x2, t}), 128'(sampleWord(0)));
        applyStimulus(0, 1, 1, 0, 0, 32'd0);
        checkOutput("rerun reinit s0", 128'({x1, x2, t}), 128'(sampleWord(0)));
        applyStimulus(0, 1, 0, 0, 0, 32'd0);
        checkOutput("rerun s1", 128'({x1, x2, t}), 128'(sampleWord(1)));
        #2 rst_n = 1'b0;
        #1 checkAllZero("midrun reset");
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        applyStimulus(1, 0, 0, 0, 0, 32'd4);
        checkOutput("replay start", 128'(start), 128'(1));
        applyStimulus(0, 0, 0, 0, 0, 32'd0);
        checkOutput("replay busy", 128'(busy), 128'(1));
        applyStimulus(0, 1, 0, 0, 0, 32'd0);
        checkOutput("replay s0", 128'({x1, x2, t}), 128'(sampleWord(0)));
        applyStimulus(0, 1, 0, 0, 0, 32'd0);
        checkOutput("replay s1", 128'({x1, x2, t}), 128'(sampleWord(1)));
        applyStimulus(0, 0, 0, 1, 0, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 32'd0);
        checkOutput("replay end busy", 128'(busy), 128'(0));
        mX = sampleWord(1);

        // Randomized runs checked against the arithmetic model
        for (int run = 0; run < 3; run++) begin
            mN = (run == 0) ? 1 : (run == 2) ? DEPTH : int'($urandom_range(DEPTH, 2));
            for (int a = 0; a < DEPTH; a++) begin
                modelMem[a] = {$urandom, $urandom, $urandom};
                writeSample(a, modelMem[a]);
            end
            applyStimulus(1, 0, 0, 0, 0, 32'(mN));
            checkOutput($sformatf("run%0d start", run), 128'(start), 128'(1));
            applyStimulus(0, 0, 0, 0, 0, 32'd0);
            mIdx = 0;
            mEpoch = 0;
            for (int c = 0; c < 40; c++) begin
                logic r, ri;
                r = 1'($urandom % 2);
                ri = ($urandom % 6) == 0;
                wr_addr = AW'($urandom);
                {wr_x1, wr_x2, wr_t} = {$urandom, $urandom, $urandom};
                if (ri) mEpoch = (mEpoch == 65535) ? 65535 : mEpoch + 1;
                if (r) begin
                    if (ri) begin
                        mX = modelMem[0];
                        mIdx = 1 % mN;
                    end else begin
                        mX = modelMem[mIdx];
                        mIdx = (mIdx + 1) % mN;
                    end
                end
                applyStimulus(0, r, ri, 0, 1'($urandom % 2), 32'd0);
                checkOutput($sformatf("run%0d c%0d sample", run, c), 128'({x1, x2, t}), 128'(mX));
                checkOutput($sformatf("run%0d c%0d epoch", run, c), 128'(epoch_cnt), 128'(mEpoch));
                checkOutput($sformatf("run%0d c%0d busy", run, c), 128'(busy), 128'(1));
                checkOutput($sformatf("run%0d c%0d n_bus", run, c), 128'(n_bus), 128'(mN));
            end
            applyStimulus(0, 1, 1, 1, 0, 32'd0);
            checkOutput($sformatf("run%0d done hold", run), 128'({x1, x2, t}), 128'(mX));
            checkOutput($sformatf("run%0d done epoch", run), 128'(epoch_cnt), 128'(mEpoch));
            applyStimulus(0, 0, 0, 0, 0, 32'd0);
            checkOutput($sformatf("run%0d idle busy", run), 128'(busy), 128'(0));
            checkOutput($sformatf("run%0d idle hold", run), 128'({x1, x2, t}), 128'(mX));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sample_feeder.md
SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the sample memory depth; legal values are powers of two from 4 to 1024.
REQ-002 SHALL have parameter DW, default 32, meaning the width of each of x1, x2 and t.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  asynchronous reset, active-low.
REQ-005 wr_en  in  1  sample write strobe.
REQ-006 wr_addr  in  log2(DEPTH)  sample write index.
REQ-007 wr_x1, wr_x2, wr_t  in  DW each  sample fields to write.
REQ-008 n_cfg  in  32  number of samples per epoch.
REQ-009 go  in  1  request to begin a training run.
REQ-010 ready  in  1  controller request for the next sample.
REQ-011 reinit  in  1  controller epoch-restart indicator.
REQ-012 done  in  1  controller training-complete pulse.
REQ-013 start  out  1  one-cycle start pulse to the controller.
REQ-014 n_bus  out  32  latched sample count driven to the controller.
REQ-015 x1, x2, t  out  DW each  currently presented sample.
REQ-016 busy  out  1  high from run start until the done pulse is seen.
REQ-017 cfg_err  out  1  one-cycle pulse when go is rejected.
REQ-018 epoch_cnt  out  16  number of completed epochs.

Function
REQ-019 FSM states SHALL be IDLE, START, FEED, FINISH; encoding is free.
REQ-020 IDLE: a write with wr_en=1 SHALL store {wr_x1, wr_x2, wr_t} at wr_addr; wr_en SHALL be ignored in every other state.
REQ-021 IDLE with go=1: if n_cfg==0 or n_cfg>DEPTH, the block SHALL pulse cfg_err for one cycle and stay in IDLE; otherwise it SHALL latch n_bus=n_cfg, clear the index and epoch_cnt, and go to START.
REQ-022 START SHALL assert start for exactly one cycle, set busy=1, and go to FEED.
REQ-023 FEED with ready=1 SHALL register mem[idx] onto x1/x2/t at that edge, so the data is stable from the next cycle until the next ready (1-cycle latency).
REQ-024 Index rule: with ready=1 and reinit=0, idx SHALL become idx+1, wrapping to 0 when idx+1==n_bus.
REQ-025 Index rule: with ready=1 and reinit=1, the block SHALL present mem[0], set idx=1 (0 if n_bus==1), and increment epoch_cnt, saturating at 0xFFFF.
REQ-026 reinit=1 with ready=0 SHALL only increment epoch_cnt and SHALL NOT change idx or the outputs.
REQ-027 FEED with done=1 SHALL go to FINISH; if done and ready are high in the same cycle, done SHALL win and x1/x2/t SHALL hold.
REQ-028 FINISH SHALL clear busy, hold x1/x2/t and epoch_cnt, and return to IDLE on the next cycle.
REQ-029 go SHALL be ignored outside IDLE.
REQ-030 The memory SHALL have one write port and one read port and SHALL be synchronous-read or registered; memory contents are not reset.

Reset
REQ-031 With rst_n=0 the block SHALL immediately force state=IDLE, start=0, busy=0, cfg_err=0, n_bus=0, x1=x2=t=0, idx=0 and epoch_cnt=0.
REQ-032 Reset asserted mid-run SHALL abort the run with no start or cfg_err pulse; memory contents are retained.
REQ-033 Reset deassertion SHALL be synchronized so that the first active edge occurs no earlier than one full clk cycle after release.

Configuration
REQ-034 Macro SAMPLE_FEEDER_EPOCH_LIMIT_EN is the single compile option.
REQ-035 With the macro defined, the block SHALL add input max_epoch[15:0] and output limit_hit[0:0]; in FEED, when epoch_cnt reaches max_epoch (and max_epoch is non-zero), it SHALL pulse limit_hit for one cycle, go to FINISH, and clear busy.
REQ-036 With the macro undefined, those ports and that logic SHALL be absent, and only done ends a run.

Verification
REQ-037 Load 4 samples, n_cfg=4, go -> one-cycle start pulse; n_bus=4; busy=1 on the cycle after START.
REQ-038 Five ready pulses with reinit=0 -> samples 0,1,2,3,0 presented, each one cycle after its ready.
REQ-039 ready and reinit high together after sample 2 -> sample 0 presented; epoch_cnt increments 0->1; the next ready presents sample 1.
REQ-040 go with n_cfg=0, and separately with n_cfg=DEPTH+1 -> cfg_err pulses once; start stays 0; state remains IDLE.
REQ-041 done and ready high in the same cycle -> x1/x2/t unchanged; busy=0 two cycles later; wr_en during the run has no effect.
REQ-042 rst_n low during FEED -> all outputs 0 at once; after reset, go replays sample 0 from the unchanged memory.
